// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite definitions for the slave-side interconnect.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package ahblite_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Data-phase select code for the built-in default slave; 0-3 are real slaves.
   localparam logic [2:0] DSEL_DEFAULT = 3'd4;

   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } ds_state_e;

   // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
   function automatic logic htrans_active(input logic [1:0] htrans);
      return htrans[1];
   endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: two-cycle ERROR for active transfers to unmapped addresses, zero-wait OKAY otherwise.
// Latency: response starts the cycle after the address phase; ready/resp are registered.
// Backpressure: only advances on HREADY=1, except DS_ERR1 which always moves on to DS_ERR2.
// Optional macro AHBLITE_SLAVE_MUX_ERRLOG_EN adds a faulting-address / count / sticky-flag log.
module ahblite_default_slave
   import ahblite_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sel_i,
   input  logic [1:0]  htrans_i,
   input  logic        hready_i,
`ifdef AHBLITE_SLAVE_MUX_ERRLOG_EN
   input  logic [31:0] haddr_i,
   output logic [31:0] err_addr_o,
   output logic [7:0]  err_cnt_o,
   output logic        err_flag_o,
`endif
   output logic        ready_o,
   output logic        resp_o
);

   ds_state_e state_q;
   logic      ready_q;
   logic      resp_q;
   logic      err_start;

   // An active unmapped transfer is accepted into the data phase; DS_ERR1 never accepts
   // because the bus is stalled by this slave in that state.
   assign err_start = hready_i & sel_i & htrans_active(htrans_i) & (state_q != DS_ERR1);

   // State machine with registered ready/resp: ERR1 stalls with ERROR, ERR2 completes ERROR.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= DS_IDLE;
         ready_q <= 1'b1;
         resp_q  <= HRESP_OKAY;
      end else begin
         unique case (state_q)
            DS_ERR1: begin
               state_q <= DS_ERR2;
               ready_q <= 1'b1;
               resp_q  <= HRESP_ERROR;
            end
            default: begin
               if (hready_i) begin
                  if (err_start) begin
                     state_q <= DS_ERR1;
                     ready_q <= 1'b0;
                     resp_q  <= HRESP_ERROR;
                  end else begin
                     state_q <= DS_IDLE;
                     ready_q <= 1'b1;
                     resp_q  <= HRESP_OKAY;
                  end
               end
            end
         endcase
      end
   end

   assign ready_o = ready_q;
   assign resp_o  = resp_q;

   logic unused_htrans;
   assign unused_htrans = htrans_i[0];

`ifdef AHBLITE_SLAVE_MUX_ERRLOG_EN
   logic [31:0] err_addr_q;
   logic [7:0]  err_cnt_q;
   logic [7:0]  err_cnt_d;
   logic        err_flag_q;

   assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

   // Capture the faulting address and bump the saturating count on each entry to DS_ERR1.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_addr_q <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
      end else if (err_start) begin
         err_addr_q <= haddr_i;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= 1'b1;
      end
   end

   assign err_addr_o = err_addr_q;
   assign err_cnt_o  = err_cnt_q;
   assign err_flag_o = err_flag_q;
`endif

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave-side interconnect: region decode to HSEL_S, data-phase select register, response mux.
// Latency: HSEL_S is combinational; data-phase select registers one cycle after the address phase.
// Backpressure: the select register holds while HREADY=0; HREADY is the selected slave's ready.
// Optional macro AHBLITE_SLAVE_MUX_ERRLOG_EN exposes ERR_ADDR / ERR_CNT / ERR_FLAG.
module ahblite_slave_mux
   import ahblite_pkg::*;
#(
   parameter logic [3:0] S0_REGION = 4'h0,
   parameter logic [3:0] S1_REGION = 4'h2,
   parameter logic [3:0] S2_REGION = 4'h4,
   parameter logic [3:0] S3_REGION = 4'h5
)
(
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   output logic [3:0]  HSEL_S,
   output logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HRESP,
`ifdef AHBLITE_SLAVE_MUX_ERRLOG_EN
   output logic [31:0] ERR_ADDR,
   output logic [7:0]  ERR_CNT,
   output logic        ERR_FLAG,
`endif
   input  logic [31:0] HRDATA_S0,
   input  logic [31:0] HRDATA_S1,
   input  logic [31:0] HRDATA_S2,
   input  logic [31:0] HRDATA_S3,
   input  logic        HREADYOUT_S0,
   input  logic        HREADYOUT_S1,
   input  logic        HREADYOUT_S2,
   input  logic        HREADYOUT_S3,
   input  logic        HRESP_S0,
   input  logic        HRESP_S1,
   input  logic        HRESP_S2,
   input  logic        HRESP_S3
);

   logic [3:0] hsel_dec;
   logic [2:0] dsel_d;
   logic [2:0] dsel_q;
   logic       ds_ready;
   logic       ds_resp;

   // Region decode on HADDR[31:28]; region parameters are expected to be distinct.
   always_comb begin
      hsel_dec = 4'b0000;
      dsel_d   = DSEL_DEFAULT;
      if (HADDR[31:28] == S0_REGION) begin
         hsel_dec = 4'b0001;
         dsel_d   = 3'd0;
      end else if (HADDR[31:28] == S1_REGION) begin
         hsel_dec = 4'b0010;
         dsel_d   = 3'd1;
      end else if (HADDR[31:28] == S2_REGION) begin
         hsel_dec = 4'b0100;
         dsel_d   = 3'd2;
      end else if (HADDR[31:28] == S3_REGION) begin
         hsel_dec = 4'b1000;
         dsel_d   = 3'd3;
      end
   end

   assign HSEL_S = hsel_dec;

   // Data-phase target: follows the decode whenever the bus completes a transfer.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_q <= DSEL_DEFAULT;
      end else if (HREADY) begin
         dsel_q <= dsel_d;
      end
   end

   ahblite_default_slave u_default_slave (
      .clk_i      (HCLK),
      .rst_i      (HRESET),
      .sel_i      (dsel_d == DSEL_DEFAULT),
      .htrans_i   (HTRANS),
      .hready_i   (HREADY),
`ifdef AHBLITE_SLAVE_MUX_ERRLOG_EN
      .haddr_i    (HADDR),
      .err_addr_o (ERR_ADDR),
      .err_cnt_o  (ERR_CNT),
      .err_flag_o (ERR_FLAG),
`endif
      .ready_o    (ds_ready),
      .resp_o     (ds_resp)
   );

`ifndef AHBLITE_SLAVE_MUX_ERRLOG_EN
   logic unused_haddr;
   assign unused_haddr = ^HADDR[27:0];
`endif

   // Return path: route the data-phase slave back to the masters, default slave reads as zero.
   always_comb begin
      HRDATA = 32'h0;
      HREADY = ds_ready;
      HRESP  = ds_resp;
      unique case (dsel_q)
         3'd0: begin
            HRDATA = HRDATA_S0;
            HREADY = HREADYOUT_S0;
            HRESP  = HRESP_S0;
         end
         3'd1: begin
            HRDATA = HRDATA_S1;
            HREADY = HREADYOUT_S1;
            HRESP  = HRESP_S1;
         end
         3'd2: begin
            HRDATA = HRDATA_S2;
            HREADY = HREADYOUT_S2;
            HRESP  = HRESP_S2;
         end
         3'd3: begin
            HRDATA = HRDATA_S3;
            HREADY = HREADYOUT_S3;
            HRESP  = HRESP_S3;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed and randomized bench for ahblite_slave_mux against a transfer-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Error-log checks are compiled in when AHBLITE_SLAVE_MUX_ERRLOG_EN is defined.
module tb_ahblite_slave_mux;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [3:0]  HSEL_S;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic [31:0] s_data [4];
   logic        s_rdy  [4];
   logic        s_resp [4];
`ifdef AHBLITE_SLAVE_MUX_ERRLOG_EN
   logic [31:0] ERR_ADDR;
   logic [7:0]  ERR_CNT;
   logic        ERR_FLAG;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the transfer currently in its data phase.
   int          m_tgt;      // 0-3 slave, 4 unmapped
   bit          m_act;      // NONSEQ/SEQ
   int          m_cyc;      // cycles already spent in this data phase
   bit          m_acc;      // last edge accepted an address phase
   logic [31:0] m_eaddr;
   int          m_ecnt;
   bit          m_eflag;
   logic        e_ready, e_resp;
   logic [31:0] e_data;
   logic [3:0]  e_hsel;

   always #5 HCLK = ~HCLK;

   ahblite_slave_mux dut (
      .HCLK         (HCLK),
      .HRESET       (HRESET),
      .HADDR        (HADDR),
      .HTRANS       (HTRANS),
      .HSEL_S       (HSEL_S),
      .HREADY       (HREADY),
      .HRDATA       (HRDATA),
      .HRESP        (HRESP),
`ifdef AHBLITE_SLAVE_MUX_ERRLOG_EN
      .ERR_ADDR     (ERR_ADDR),
      .ERR_CNT      (ERR_CNT),
      .ERR_FLAG     (ERR_FLAG),
`endif
      .HRDATA_S0    (s_data[0]),
      .HRDATA_S1    (s_data[1]),
      .HRDATA_S2    (s_data[2]),
      .HRDATA_S3    (s_data[3]),
      .HREADYOUT_S0 (s_rdy[0]),
      .HREADYOUT_S1 (s_rdy[1]),
      .HREADYOUT_S2 (s_rdy[2]),
      .HREADYOUT_S3 (s_rdy[3]),
      .HRESP_S0     (s_resp[0]),
      .HRESP_S1     (s_resp[1]),
      .HRESP_S2     (s_resp[2]),
      .HRESP_S3     (s_resp[3])
   );

   function automatic int region_of(input logic [31:0] a);
      case (a[31:28])
         4'h0:    return 0;
         4'h2:    return 1;
         4'h4:    return 2;
         4'h5:    return 3;
         default: return 4;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Falling edge: compute expected outputs from the model and compare.
   task automatic settle();
      int r;
      @(negedge HCLK);
      r = region_of(HADDR);
      e_hsel = (r < 4) ? (4'b0001 << r) : 4'b0000;
      if (m_tgt < 4) begin
         e_ready = s_rdy[m_tgt];
         e_resp  = s_resp[m_tgt];
         e_data  = s_data[m_tgt];
      end else if (m_act) begin
         e_ready = (m_cyc != 0);
         e_resp  = 1'b1;
         e_data  = 32'h0;
      end else begin
         e_ready = 1'b1;
         e_resp  = 1'b0;
         e_data  = 32'h0;
      end
      chk("hsel",   {28'h0, HSEL_S}, {28'h0, e_hsel});
      chk("hready", {31'h0, HREADY}, {31'h0, e_ready});
      chk("hresp",  {31'h0, HRESP},  {31'h0, e_resp});
      chk("hrdata", HRDATA, e_data);
`ifdef AHBLITE_SLAVE_MUX_ERRLOG_EN
      chk("err_addr", ERR_ADDR, m_eaddr);
      chk("err_cnt",  {24'h0, ERR_CNT}, 32'(m_ecnt));
      chk("err_flag", {31'h0, ERR_FLAG}, {31'h0, m_eflag});
`endif
   endtask

   // Rising edge: advance the model, then give the DUT 1 unit before new stimulus.
   task automatic adv();
      int r;
      @(posedge HCLK);
      m_acc = 1'b0;
      if (HRESET) begin
         m_tgt = 4; m_act = 1'b0; m_cyc = 0;
         m_eaddr = 32'h0; m_ecnt = 0; m_eflag = 1'b0;
      end else if (e_ready) begin
         r = region_of(HADDR);
         if (r == 4 && HTRANS[1]) begin
            m_eaddr = HADDR;
            m_ecnt  = (m_ecnt < 255) ? m_ecnt + 1 : 255;
            m_eflag = 1'b1;
         end
         m_tgt = r; m_act = HTRANS[1]; m_cyc = 0; m_acc = 1'b1;
      end else begin
         m_cyc++;
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic [3:0] nib;
      m_tgt = 4; m_act = 1'b0; m_cyc = 0; m_acc = 1'b0;
      m_eaddr = 32'h0; m_ecnt = 0; m_eflag = 1'b0;
      HRESET = 1'b1; HADDR = 32'h2000_0000; HTRANS = 2'b00;
      for (int k = 0; k < 4; k++) begin
         s_data[k] = 32'h0; s_rdy[k] = 1'b1; s_resp[k] = 1'b0;
      end

      // Reset held for two edges; outputs idle, decode still live.
      @(posedge HCLK); #1;
      settle();
      chk("rst_hready", {31'h0, HREADY}, 32'd1);
      chk("rst_hsel",   {28'h0, HSEL_S}, 32'h2);
      adv();
      HRESET = 1'b0;
      settle();
      chk("post_rst_hresp",  {31'h0, HRESP}, 32'd0);
      chk("post_rst_hrdata", HRDATA, 32'h0);
      adv();

      // Mapped read to slave 1 with two wait states.
      HADDR = 32'h2000_0010; HTRANS = 2'b10;
      settle(); adv();
      HADDR = 32'hF000_0000; HTRANS = 2'b00;
      s_rdy[1] = 1'b0; s_data[1] = 32'h1111_2222;
      settle();
      chk("wait1_hready", {31'h0, HREADY}, 32'd0);
      chk("wait1_hold",   HRDATA, 32'h1111_2222);
      adv();
      settle();
      chk("wait2_hready", {31'h0, HREADY}, 32'd0);
      adv();
      s_rdy[1] = 1'b1; s_data[1] = 32'hDEAD_BEEF;
      settle();
      chk("read_data",  HRDATA, 32'hDEAD_BEEF);
      chk("read_resp",  {31'h0, HRESP}, 32'd0);
      adv();

      // Unmapped NONSEQ: ERROR pair; the preceding IDLE at the same address is a zero-wait OKAY.
      HTRANS = 2'b10;
      settle();
      chk("unmap_idle_ok", {30'h0, HREADY, HRESP}, 32'b10);
      chk("unmap_hsel",    {28'h0, HSEL_S}, 32'h0);
      adv();
      HTRANS = 2'b00;
      settle();
      chk("err1", {30'h0, HREADY, HRESP}, 32'b01);
      adv();
      settle();
      chk("err2", {30'h0, HREADY, HRESP}, 32'b11);
      adv();
      settle(); adv();

      // Back-to-back: slave 0, slave 2, unmapped, slave 1.
      s_data[0] = 32'hA0A0_0000; s_data[1] = 32'hA1A1_1111;
      s_data[2] = 32'hA2A2_2222; s_data[3] = 32'hA3A3_3333;
      HADDR = 32'h0000_0100; HTRANS = 2'b10;
      settle(); adv();
      HADDR = 32'h4000_0200;
      settle();
      chk("b2b_s0", HRDATA, 32'hA0A0_0000);
      adv();
      HADDR = 32'h9000_0000;
      settle();
      chk("b2b_s2", HRDATA, 32'hA2A2_2222);
      adv();
      HADDR = 32'h2000_0300;
      settle();
      chk("b2b_err1", {30'h0, HREADY, HRESP}, 32'b01);
      adv();
      settle();
      chk("b2b_err2", {30'h0, HREADY, HRESP}, 32'b11);
      adv();
      HTRANS = 2'b00;
      settle();
      chk("b2b_s1", HRDATA, 32'hA1A1_1111);
      chk("b2b_s1_ok", {30'h0, HREADY, HRESP}, 32'b10);
      adv();

      // Reset during DS_ERR1.
      HADDR = 32'hF000_0000; HTRANS = 2'b10;
      settle(); adv();
      HTRANS = 2'b00;
      settle();
      chk("mid_err1", {30'h0, HREADY, HRESP}, 32'b01);
      HRESET = 1'b1;
      adv();
      HRESET = 1'b0;
      settle();
      chk("mid_err_rst", {30'h0, HREADY, HRESP}, 32'b10);
      adv();

      // Randomized traffic, slave behaviour and occasional reset.
      for (int i = 0; i < 2000; i++) begin
         n = $urandom_range(0, 7);
         case (n)
            0: nib = 4'h0;
            1: nib = 4'h2;
            2: nib = 4'h4;
            3: nib = 4'h5;
            default: nib = 4'($urandom_range(0, 15));
         endcase
         HADDR  = {nib, 28'($urandom)};
         HTRANS = 2'($urandom_range(0, 3));
         HRESET = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < 4; k++) begin
            s_rdy[k]  = ($urandom_range(0, 3) != 0);
            s_resp[k] = ($urandom_range(0, 7) == 0);
            s_data[k] = $urandom;
         end
         settle(); adv();
      end
      HRESET = 1'b0;
      for (int k = 0; k < 4; k++) s_rdy[k] = 1'b1;

`ifdef AHBLITE_SLAVE_MUX_ERRLOG_EN
      // 300 unmapped NONSEQ transfers; count saturates, last address logged.
      for (int i = 0; i < 300; i++) begin
         HADDR  = (i == 299) ? 32'hC000_0004 : {4'($urandom_range(6, 15)), 28'($urandom)};
         HTRANS = 2'b10;
         n = 0; m_acc = 1'b0;
         while (!m_acc && n < 4) begin
            settle(); adv(); n++;
         end
         chk("errlog_accept", {31'h0, m_acc}, 32'd1);
      end
      HTRANS = 2'b00;
      settle(); adv();
      settle(); adv();
      settle();
      chk("errlog_cnt",  {24'h0, ERR_CNT}, 32'hFF);
      chk("errlog_addr", ERR_ADDR, 32'hC000_0004);
      chk("errlog_flag", {31'h0, ERR_FLAG}, 32'd1);
      adv();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
AHB-Lite slave-side interconnect. It sits on the single shared bus driven by the master mux. It decodes the address phase into per-slave HSEL lines. It registers the selected slave for the data phase and returns that slave's HRDATA/HREADYOUT/HRESP to the masters as HRDATA/HREADY/HRESP. It contains a built-in default slave that gives a two-cycle ERROR response to active transfers at unmapped addresses.

Parameters:
- S0_REGION, 4'h0, HADDR[31:28] value selecting slave 0 (code/ROM)
- S1_REGION, 4'h2, HADDR[31:28] value selecting slave 1 (SRAM)
- S2_REGION, 4'h4, HADDR[31:28] value selecting slave 2 (peripherals)
- S3_REGION, 4'h5, HADDR[31:28] value selecting slave 3 (DMA regs)

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  synchronous reset, active-high
- HADDR  in  32  address-phase address from master mux
- HTRANS  in  2  transfer type from master mux
- HSEL_S  out  4  one-hot address-phase slave select; bit n selects slave n
- HREADY  out  1  muxed ready; goes to the masters and is fed back to all slaves
- HRDATA  out  32  muxed read data
- HRESP  out  1  muxed response (0 OKAY, 1 ERROR)
- HRDATA_S0..HRDATA_S3  in  32 each  slave read data
- HREADYOUT_S0..HREADYOUT_S3  in  1 each  slave ready
- HRESP_S0..HRESP_S3  in  1 each  slave response

Behaviour:
- Decode is combinational on HADDR[31:28]. HSEL_S[n]=1 when the region field matches Sn_REGION; otherwise HSEL_S=0 and the default slave is addressed. Region parameters must be distinct.
- HSEL_S is independent of HTRANS; slaves qualify the transfer with HTRANS themselves.
- Data-phase select register dsel[2:0] encodes 0-3 for a slave and 4 for the default slave. It loads the decoded target on a rising HCLK edge only when HREADY=1. While HREADY=0 it holds.
- Output mux: when dsel=n, HRDATA/HREADY/HRESP come from slave n. When dsel=default, HRDATA=32'h0 and HREADY/HRESP come from the default-slave FSM.
- Default-slave FSM states:
  - DS_IDLE: outputs ready=1, resp=0. On a load of dsel=default with HTRANS[1]=1 (NONSEQ or SEQ), go to DS_ERR1. With IDLE or BUSY, stay in DS_IDLE, giving a zero-wait OKAY.
  - DS_ERR1: outputs ready=0, resp=1. Always goes to DS_ERR2.
  - DS_ERR2: outputs ready=1, resp=1. Takes the next address phase like DS_IDLE: an active unmapped transfer goes to DS_ERR1, anything else goes to DS_IDLE.
- The default slave returns no OKAY responses to active transfers. IDLE/BUSY at mapped addresses are handled by the addressed slave.
- Back-to-back transfers: an active unmapped transfer immediately after a mapped one inserts exactly the two ERROR cycles; no extra bubble.
- Reset, from any state and including mid-wait-state: dsel=default, FSM=DS_IDLE. Outputs are then HREADY=1, HRESP=0, HRDATA=0. HSEL_S still follows HADDR.
- Latency: address phase to data-phase select is 1 cycle. Output muxing adds no extra register.

Optional Feature:
- Macro: AHBLITE_SLAVE_MUX_ERRLOG_EN.
- Defined: adds outputs ERR_ADDR (32), ERR_CNT (8) and ERR_FLAG (1).
  - On each entry to DS_ERR1, the faulting address-phase HADDR is captured into ERR_ADDR, the address having been registered alongside dsel.
  - ERR_CNT increments on each entry and saturates at 8'hFF.
  - ERR_FLAG is a sticky 1.
  - All three reset to 0 on HRESET.
- Undefined: these ports and registers do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package ahblite_pkg:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/HRESP_ERROR
  - DSEL_DEFAULT=3'd4
  - default-slave FSM state typedef
- Sub-module ahblite_default_slave: holds the FSM and the optional error log. Inputs are sel-active, HTRANS and HREADY; outputs are its own ready/resp.

Test Plan:
- Reset check: assert HRESET for 2 cycles with HADDR=32'h2000_0000 -> during and after reset, HREADY=1, HRESP=0, HRDATA=0, HSEL_S=4'b0010.
- Mapped read with wait states: NONSEQ read 32'h2000_0010; slave 1 holds HREADYOUT_S1=0 for 2 cycles, then returns HRDATA_S1=32'hDEAD_BEEF -> HREADY low for 2 cycles, then HRDATA=32'hDEAD_BEEF, HRESP=0. dsel holds 1 throughout the wait.
- Unmapped access: NONSEQ at 32'hF000_0000 -> HSEL_S=0; data phase gives HREADY=0/HRESP=1 for one cycle, then HREADY=1/HRESP=1 for one cycle. An IDLE at the same address gives a zero-wait OKAY.
- Back-to-back crossing regions: NONSEQ to slave 0, then slave 2, then unmapped, then slave 1 -> each data phase is sourced from the correct slave. The ERROR pair appears only in the third data phase, and slave 1's data phase follows immediately.
- Reset mid-error: assert HRESET during DS_ERR1 -> the next cycle shows HREADY=1, HRESP=0, FSM in DS_IDLE.
- ERRLOG, with the macro defined: 300 unmapped NONSEQ accesses, the last at 32'hC000_0004 -> ERR_CNT=8'hFF, ERR_ADDR=32'hC000_0004, ERR_FLAG=1.
